// File: rtl/hsid_x_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : hsid_x_reg_master (with package hsid_x_reg_pkg)
// Brief    : Drives one HSpecID-X job over the register bus: programs the
//            job registers, starts it, polls STATUS and reads back MSE results.
// Options  : define HSID_X_REG_MASTER_TIMEOUT_EN to abort after 1024 polls.
// Revision : 1.0 - initial release
// ============================================================================

package hsid_x_reg_pkg;
    localparam int unsigned HSID_WORD_WIDTH        = 32;
    localparam int unsigned HSID_HSP_BANDS_WIDTH   = 12;
    localparam int unsigned HSID_HSP_LIBRARY_WIDTH = 16;

    typedef struct packed {
        logic [HSID_WORD_WIDTH-1:0]   addr;
        logic                         write;
        logic [HSID_WORD_WIDTH-1:0]   wdata;
        logic [HSID_WORD_WIDTH/8-1:0] wstrb;
        logic                         valid;
    } reg_req_t;

    typedef struct packed {
        logic [HSID_WORD_WIDTH-1:0] rdata;
        logic                       error;
        logic                       ready;
    } reg_rsp_t;
endpackage

module hsid_x_reg_master
    import hsid_x_reg_pkg::*;
#(
    parameter int unsigned          WORD_WIDTH        = HSID_WORD_WIDTH,
    parameter int unsigned          HSP_BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int unsigned          HSP_LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH,
    parameter logic [WORD_WIDTH-1:0] BASE_ADDR        = '0,
    parameter int unsigned          POLL_INTERVAL     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [HSP_LIBRARY_WIDTH-1:0] cmd_library_size,
    input  logic [HSP_BANDS_WIDTH-1:0]   cmd_pixel_bands,
    input  logic [WORD_WIDTH-1:0]        cmd_captured_addr,
    input  logic [WORD_WIDTH-1:0]        cmd_library_addr,
    output reg_req_t                     reg_req,
    input  reg_rsp_t                     reg_rsp,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2:0]                   res_status,
    output logic                         res_bus_error,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_min_ref,
    output logic [HSP_LIBRARY_WIDTH-1:0] res_max_ref,
    output logic [WORD_WIDTH-1:0]        res_min_value,
    output logic [WORD_WIDTH-1:0]        res_max_value
);

    localparam logic [7:0] c_OFF_STATUS  = 8'h00;
    localparam logic [7:0] c_OFF_SIZE    = 8'h04;
    localparam logic [7:0] c_OFF_BANDS   = 8'h08;
    localparam logic [7:0] c_OFF_CAP     = 8'h0C;
    localparam logic [7:0] c_OFF_LIB     = 8'h10;
    localparam logic [7:0] c_OFF_MINREF  = 8'h14;
    localparam logic [7:0] c_OFF_MINVAL  = 8'h18;
    localparam logic [7:0] c_OFF_MAXREF  = 8'h1C;
    localparam logic [7:0] c_OFF_MAXVAL  = 8'h20;
    localparam int unsigned c_WCW        = $clog2(POLL_INTERVAL) + 1;
    localparam logic [c_WCW-1:0] c_WAIT_LAST = c_WCW'(POLL_INTERVAL - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_SIZE, S_WR_BANDS, S_WR_CAP, S_WR_LIB, S_WR_START,
        S_WAIT, S_POLL, S_RD_MINREF, S_RD_MINVAL, S_RD_MAXREF, S_RD_MAXVAL,
        S_RESP, S_WR_CLEAR
    } state_e;

    state_e                         state_q;
    reg_req_t                       req_q;
    logic                           cmd_ready_q;
    logic [HSP_LIBRARY_WIDTH-1:0]   size_q;
    logic [HSP_BANDS_WIDTH-1:0]     bands_q;
    logic [WORD_WIDTH-1:0]          cap_q;
    logic [WORD_WIDTH-1:0]          lib_q;
    logic [c_WCW-1:0]               wait_cnt_q;
    logic                           res_valid_q;
    logic [2:0]                     res_status_q;
    logic                           res_bus_error_q;
    logic [HSP_LIBRARY_WIDTH-1:0]   res_min_ref_q;
    logic [HSP_LIBRARY_WIDTH-1:0]   res_max_ref_q;
    logic [WORD_WIDTH-1:0]          res_min_value_q;
    logic [WORD_WIDTH-1:0]          res_max_value_q;
`ifdef HSID_X_REG_MASTER_TIMEOUT_EN
    logic [9:0]                     poll_cnt_q;
`endif

    function automatic reg_req_t bus_op(input logic [7:0] off, input logic wr,
                                        input logic [WORD_WIDTH-1:0] data);
        bus_op       = '0;
        bus_op.addr  = BASE_ADDR + WORD_WIDTH'(off);
        bus_op.write = wr;
        bus_op.wdata = wr ? data : '0;
        bus_op.wstrb = '1;
        bus_op.valid = 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            req_q           <= '0;
            cmd_ready_q     <= 1'b1;
            size_q          <= '0;
            bands_q         <= '0;
            cap_q           <= '0;
            lib_q           <= '0;
            wait_cnt_q      <= '0;
            res_valid_q     <= 1'b0;
            res_status_q    <= '0;
            res_bus_error_q <= 1'b0;
            res_min_ref_q   <= '0;
            res_max_ref_q   <= '0;
            res_min_value_q <= '0;
            res_max_value_q <= '0;
`ifdef HSID_X_REG_MASTER_TIMEOUT_EN
            poll_cnt_q      <= '0;
`endif
        end else if (req_q.valid && reg_rsp.ready && reg_rsp.error) begin
            // Any failed transaction ends the job; nothing further is issued.
            req_q           <= '0;
            res_bus_error_q <= 1'b1;
            res_valid_q     <= 1'b1;
            state_q         <= S_RESP;
        end else begin
            case (state_q)
                S_IDLE: if (cmd_valid && cmd_ready_q) begin
                    size_q          <= cmd_library_size;
                    bands_q         <= cmd_pixel_bands;
                    cap_q           <= cmd_captured_addr;
                    lib_q           <= cmd_library_addr;
                    cmd_ready_q     <= 1'b0;
                    res_status_q    <= '0;
                    res_bus_error_q <= 1'b0;
                    res_min_ref_q   <= '0;
                    res_max_ref_q   <= '0;
                    res_min_value_q <= '0;
                    res_max_value_q <= '0;
`ifdef HSID_X_REG_MASTER_TIMEOUT_EN
                    poll_cnt_q      <= '0;
`endif
                    req_q   <= bus_op(c_OFF_SIZE, 1'b1, WORD_WIDTH'(cmd_library_size));
                    state_q <= S_WR_SIZE;
                end
                S_WR_SIZE: if (reg_rsp.ready) begin
                    req_q   <= bus_op(c_OFF_BANDS, 1'b1, WORD_WIDTH'(bands_q));
                    state_q <= S_WR_BANDS;
                end
                S_WR_BANDS: if (reg_rsp.ready) begin
                    req_q   <= bus_op(c_OFF_CAP, 1'b1, cap_q);
                    state_q <= S_WR_CAP;
                end
                S_WR_CAP: if (reg_rsp.ready) begin
                    req_q   <= bus_op(c_OFF_LIB, 1'b1, lib_q);
                    state_q <= S_WR_LIB;
                end
                S_WR_LIB: if (reg_rsp.ready) begin
                    req_q   <= bus_op(c_OFF_STATUS, 1'b1, WORD_WIDTH'(1));
                    state_q <= S_WR_START;
                end
                S_WR_START: if (reg_rsp.ready) begin
                    req_q      <= '0;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt_q == c_WAIT_LAST) begin
                        wait_cnt_q <= '0;
                        req_q      <= bus_op(c_OFF_STATUS, 1'b0, '0);
                        state_q    <= S_POLL;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_POLL: if (reg_rsp.ready) begin
                    // Bits 6:4 are cancelled/error/done; any of them ends the job.
                    if (|reg_rsp.rdata[6:4]) begin
                        res_status_q <= reg_rsp.rdata[6:4];
                        req_q        <= bus_op(c_OFF_MINREF, 1'b0, '0);
                        state_q      <= S_RD_MINREF;
`ifdef HSID_X_REG_MASTER_TIMEOUT_EN
                    end else if (poll_cnt_q == 10'd1023) begin
                        req_q   <= bus_op(c_OFF_STATUS, 1'b1, WORD_WIDTH'(2));
                        state_q <= S_WR_CLEAR;
                    end else begin
                        poll_cnt_q <= poll_cnt_q + 1'b1;
                        req_q      <= '0;
                        state_q    <= S_WAIT;
`else
                    end else begin
                        req_q   <= '0;
                        state_q <= S_WAIT;
`endif
                    end
                end
                S_RD_MINREF: if (reg_rsp.ready) begin
                    res_min_ref_q <= reg_rsp.rdata[HSP_LIBRARY_WIDTH-1:0];
                    req_q         <= bus_op(c_OFF_MINVAL, 1'b0, '0);
                    state_q       <= S_RD_MINVAL;
                end
                S_RD_MINVAL: if (reg_rsp.ready) begin
                    res_min_value_q <= reg_rsp.rdata;
                    req_q           <= bus_op(c_OFF_MAXREF, 1'b0, '0);
                    state_q         <= S_RD_MAXREF;
                end
                S_RD_MAXREF: if (reg_rsp.ready) begin
                    res_max_ref_q <= reg_rsp.rdata[HSP_LIBRARY_WIDTH-1:0];
                    req_q         <= bus_op(c_OFF_MAXVAL, 1'b0, '0);
                    state_q       <= S_RD_MAXVAL;
                end
                S_RD_MAXVAL: if (reg_rsp.ready) begin
                    res_max_value_q <= reg_rsp.rdata;
                    req_q           <= '0;
                    res_valid_q     <= 1'b1;
                    state_q         <= S_RESP;
                end
                S_WR_CLEAR: if (reg_rsp.ready) begin
                    req_q           <= '0;
                    res_bus_error_q <= 1'b1;
                    res_valid_q     <= 1'b1;
                    state_q         <= S_RESP;
                end
                S_RESP: if (res_ready) begin
                    res_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    req_q       <= '0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign reg_req       = req_q;
    assign res_valid     = res_valid_q;
    assign res_status    = res_status_q;
    assign res_bus_error = res_bus_error_q;
    assign res_min_ref   = res_min_ref_q;
    assign res_max_ref   = res_max_ref_q;
    assign res_min_value = res_min_value_q;
    assign res_max_value = res_max_value_q;

endmodule

`default_nettype wire

// File: tb/tb_hsid_x_reg_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_hsid_x_reg_master
// Brief    : Randomized register-bus responder and job-level reference model
//            for hsid_x_reg_master.
// Revision : 1.0 - initial release
// ============================================================================

module tb_hsid_x_reg_master;
    import hsid_x_reg_pkg::*;

    localparam int          POLL = 4;
    localparam int          LW   = HSID_HSP_LIBRARY_WIDTH;
    localparam int          BW   = HSID_HSP_BANDS_WIDTH;
    localparam logic [31:0] BASE = 32'h4000_0100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_library_size = '0;
    logic [BW-1:0] cmd_pixel_bands = '0;
    logic [31:0]   cmd_captured_addr = '0;
    logic [31:0]   cmd_library_addr = '0;
    reg_req_t      reg_req;
    reg_rsp_t      reg_rsp = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [2:0]    res_status;
    logic          res_bus_error;
    logic [LW-1:0] res_min_ref, res_max_ref;
    logic [31:0]   res_min_value, res_max_value;

    always #5 clk = ~clk;

    hsid_x_reg_master #(
        .BASE_ADDR    (BASE),
        .POLL_INTERVAL(POLL)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_library_size (cmd_library_size),
        .cmd_pixel_bands  (cmd_pixel_bands),
        .cmd_captured_addr(cmd_captured_addr),
        .cmd_library_addr (cmd_library_addr),
        .reg_req          (reg_req),
        .reg_rsp          (reg_rsp),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_status       (res_status),
        .res_bus_error    (res_bus_error),
        .res_min_ref      (res_min_ref),
        .res_max_ref      (res_max_ref),
        .res_min_value    (res_min_value),
        .res_max_value    (res_max_value)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: the job as an ordered list of bus transactions.
    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] status_q[$];
    logic [31:0] mse[4];
    int          err_at     = -1;
    int          txn_idx    = 0;
    int          stall_left = 0;
    bit          rand_ready = 1'b1;

    function automatic txn_t mk(input logic [7:0] off, input bit wr, input logic [31:0] d);
        mk.addr = BASE + 32'(off);
        mk.wr   = wr;
        mk.data = d;
    endfunction

    // Bus responder, acting on the falling edge.
    int       ncyc = 0, hs_cyc = 0;
    bit       gap_pending = 1'b0, gap_poll = 1'b0;
    bit       prev_valid = 1'b0, prev_ready = 1'b0;
    reg_req_t prev_req = '0;
    txn_t     cur;
    bit       rdy;

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            reg_rsp     = '0;
            prev_valid  = 1'b0;
            prev_ready  = 1'b0;
            gap_pending = 1'b0;
        end else begin
            reg_rsp = '0;
            if (reg_req.valid) begin
                if (prev_valid && !prev_ready) begin
                    check_val("req_stable_addr_data", {reg_req.addr, reg_req.wdata},
                              {prev_req.addr, prev_req.wdata});
                    check_val("req_stable_write", reg_req.write, prev_req.write);
                end
                if (gap_pending) begin
                    check_val(gap_poll ? "poll_gap" : "next_gap", ncyc - hs_cyc,
                              gap_poll ? POLL + 1 : 1);
                    gap_pending = 1'b0;
                end
                if (stall_left > 0 && reg_req.write && reg_req.addr == BASE + 32'h8) begin
                    stall_left--;
                    rdy = 1'b0;
                end else begin
                    rdy = !rand_ready || ($urandom_range(0, 3) != 0);
                end
                if (rdy) begin
                    reg_rsp.ready = 1'b1;
                    check_val("txn_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur = exp_q.pop_front();
                        check_val("txn_addr", reg_req.addr, cur.addr);
                        check_val("txn_write", reg_req.write, cur.wr);
                        if (cur.wr) begin
                            check_val("txn_wdata", reg_req.wdata, cur.data);
                            check_val("txn_wstrb", reg_req.wstrb, 4'hF);
                        end else begin
                            case (reg_req.addr - BASE)
                                32'h00:  reg_rsp.rdata = (status_q.size() != 0) ?
                                                         status_q.pop_front() : 32'h10;
                                32'h14:  reg_rsp.rdata = mse[0];
                                32'h18:  reg_rsp.rdata = mse[1];
                                32'h1C:  reg_rsp.rdata = mse[2];
                                32'h20:  reg_rsp.rdata = mse[3];
                                default: reg_rsp.rdata = 32'hDEAD_BEEF;
                            endcase
                        end
                    end
                    reg_rsp.error = (txn_idx == err_at);
                    txn_idx++;
                    if (!reg_rsp.error && exp_q.size() != 0) begin
                        gap_pending = 1'b1;
                        hs_cyc      = ncyc;
                        gap_poll    = (exp_q[0].addr == BASE) && !exp_q[0].wr;
                    end
                end
            end
            prev_valid = reg_req.valid;
            prev_ready = reg_rsp.ready;
            prev_req   = reg_req;
        end
    end

    // mode 0: random job, 1: fixed job values, 2: always-busy STATUS (timeout)
    logic [2:0] exp_status;

    task automatic start_job(input int mode, input int nterm, input int err_idx, input bit stall);
        logic [LW-1:0] size;
        logic [BW-1:0] bands;
        logic [31:0]   cap, lib, term;
        size  = LW'($urandom);
        bands = BW'($urandom);
        cap   = $urandom;
        lib   = $urandom;
        for (int i = 0; i < 4; i++) mse[i] = $urandom;
        term  = ($urandom & ~32'h70) | (32'($urandom_range(1, 7)) << 4);
        if (mode == 1) begin
            size = LW'(8); bands = BW'(4); cap = 32'h1000; lib = 32'h2000;
            mse[0] = 32'd3; mse[1] = 32'h55; mse[2] = 32'd7; mse[3] = 32'h99;
            term = 32'h1C;
        end
        exp_q.delete();
        status_q.delete();
        exp_q.push_back(mk(8'h04, 1, 32'(size)));
        exp_q.push_back(mk(8'h08, 1, 32'(bands)));
        exp_q.push_back(mk(8'h0C, 1, cap));
        exp_q.push_back(mk(8'h10, 1, lib));
        exp_q.push_back(mk(8'h00, 1, 32'h1));
        for (int i = 0; i < nterm; i++) begin
            status_q.push_back(mode == 0 ? ($urandom & ~32'h70) : 32'h0C);
            exp_q.push_back(mk(8'h00, 0, 0));
        end
        if (mode == 2) begin
            exp_q.push_back(mk(8'h00, 1, 32'h2));
        end else begin
            status_q.push_back(term);
            exp_q.push_back(mk(8'h00, 0, 0));
            exp_q.push_back(mk(8'h14, 0, 0));
            exp_q.push_back(mk(8'h18, 0, 0));
            exp_q.push_back(mk(8'h1C, 0, 0));
            exp_q.push_back(mk(8'h20, 0, 0));
        end
        if (err_idx >= 0)
            while (exp_q.size() > err_idx + 1) void'(exp_q.pop_back());
        exp_status = term[6:4];
        err_at     = err_idx;
        txn_idx    = 0;
        stall_left = stall ? 5 : 0;
        rand_ready = (mode == 0);

        @(negedge clk);
        check_val("cmd_ready_idle", cmd_ready, 1);
        cmd_valid         = 1'b1;
        cmd_library_size  = size;
        cmd_pixel_bands   = bands;
        cmd_captured_addr = cap;
        cmd_library_addr  = lib;
        @(negedge clk);
        cmd_valid         = 1'b0;
        check_val("cmd_ready_busy", cmd_ready, 0);
    endtask

    task automatic finish_job(input bit exp_err, input bit check_results);
        int            cyc;
        int            hold;
        logic [31:0]   snap;
        cyc = 0;
        while (!res_valid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("res_valid_arrives", res_valid, 1);
        check_val("res_bus_error", res_bus_error, exp_err);
        check_val("txn_all_done", exp_q.size(), 0);
        if (check_results) begin
            check_val("res_status", res_status, exp_status);
            check_val("res_min_ref", res_min_ref, mse[0][LW-1:0]);
            check_val("res_min_value", res_min_value, mse[1]);
            check_val("res_max_ref", res_max_ref, mse[2][LW-1:0]);
            check_val("res_max_value", res_max_value, mse[3]);
        end
        snap = res_max_value;
        hold = $urandom_range(0, 3);
        repeat (hold) @(negedge clk);
        check_val("res_valid_hold", res_valid, 1);
        check_val("res_value_stable", res_max_value, snap);
        check_val("req_idle_in_resp", reg_req.valid, 0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("res_valid_drop", res_valid, 0);
        check_val("cmd_ready_back", cmd_ready, 1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_cmd_ready", cmd_ready, 1);
        check_val("rst_req_valid", reg_req.valid, 0);
        check_val("rst_req_write", reg_req.write, 0);
        check_val("rst_req_addr_data", {reg_req.addr, reg_req.wdata}, 0);
        check_val("rst_res_valid", res_valid, 0);
        check_val("rst_res_flags", {res_bus_error, res_status}, 0);
        check_val("rst_res_values", {res_min_ref, res_max_ref, res_min_value}, 0);
        rst = 1'b0;

        // Fixed job: two busy polls then done
        start_job(1, 2, -1, 1'b0);
        finish_job(1'b0, 1'b1);

        // WR_BANDS held off for five cycles
        start_job(1, 0, -1, 1'b1);
        finish_job(1'b0, 1'b1);

        // Error on the CAPTURED_PIXEL_ADDR write
        start_job(1, 0, 2, 1'b0);
        finish_job(1'b1, 1'b0);

        for (int j = 0; j < 24; j++) begin
            int e;
            e = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
            start_job(0, $urandom_range(0, 3), e, $urandom_range(0, 1));
            finish_job(e >= 0, e < 0);
        end

        // Reset while a STATUS poll is outstanding
        start_job(0, 40, -1, 1'b0);
        cyc = 0;
        while (!(reg_req.valid && reg_req.addr == BASE && !reg_req.write) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check_val("poll_reached", reg_req.valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_poll_rst_valid", reg_req.valid, 0);
        check_val("mid_poll_rst_cmd_ready", cmd_ready, 1);
        check_val("mid_poll_rst_res_valid", res_valid, 0);
        rst = 1'b0;

        start_job(0, 1, -1, 1'b0);
        finish_job(1'b0, 1'b1);

`ifdef HSID_X_REG_MASTER_TIMEOUT_EN
        start_job(2, 1024, -1, 1'b0);
        finish_job(1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
